// File: rtl/l2_pkg.sv
// Shared definitions for the L2 cache controller.
//   - Address geometry: 64-byte lines, 32 sets, 4 ways.
//   - state_t : controller FSM states.
//   - line_addr() : builds a line-aligned byte address from a tag and a set index.
package l2_pkg;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 5;
  localparam int WAYS     = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS     = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FETCH,
    REFILL,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                  input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_cache_controller_replace.sv
// Per-set replacement state for the L2 (module l2_replace).
// Build option: L2_PLRU_EN
//   defined   : 3-bit tree pseudo-LRU per set, updated by touch; victim is the PLRU leaf.
//   undefined : 2-bit round-robin pointer per set, advanced by alloc; victim is the pointer.
// Ports:
//   clk, nrst  : clock, synchronous active-low reset (clears all replacement state)
//   set_idx    : set being looked up / updated
//   touch      : access to used_way of set_idx has completed
//   alloc      : a line is being refilled into set_idx
//   used_way   : way that was touched
//   victim     : replacement candidate for set_idx (combinational)
module l2_replace
  import l2_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic [INDEX_W-1:0] set_idx,
  input  logic               touch,
  input  logic               alloc,
  input  logic [1:0]         used_way,
  output logic [1:0]         victim
);

`ifdef L2_PLRU_EN
  // bit 0: root (0 = evict from ways 0/1, 1 = from ways 2/3)
  // bit 1: pair 0/1 (0 = way 0, 1 = way 1); bit 2: pair 2/3 (0 = way 2, 1 = way 3)
  logic [2:0] tree [SETS];
  logic [2:0] cur;
  logic       unused_alloc;

  assign cur          = tree[set_idx];
  assign unused_alloc = alloc;
  assign victim       = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
    end else if (touch) begin
      // point every node on the touched path away from the touched leaf
      if (!used_way[1]) tree[set_idx] <= {cur[2], ~used_way[0], 1'b1};
      else              tree[set_idx] <= {~used_way[0], cur[1], 1'b0};
    end
  end
`else
  logic [1:0] ptr [SETS];
  logic       unused_touch;

  assign unused_touch = ^{touch, used_way};
  assign victim       = ptr[set_idx];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else if (alloc) begin
      ptr[set_idx] <= ptr[set_idx] + 2'd1;
    end
  end
`endif

endmodule

// File: rtl/l2_cache_controller.sv
// L2 cache controller: tag/valid/dirty state for 32 sets x 4 ways, hit/miss
// resolution, victim write-back and line fetch sequencing. Carries no data.
// Build option: L2_PLRU_EN selects tree PLRU replacement (default: round-robin).
// Ports:
//   clk, nrst    : clock, synchronous active-low reset
//   l1_req/l1_we/l1_addr : L1 request (held by L1 until l2_ready), 1 = line write-back
//   l2_ready     : one-cycle completion pulse
//   index_L1_L2, way : data array set/way select (stable from COMPARE through DONE)
//   update       : data array write strobe for L1 data (DONE of a write)
//   refill       : data array write strobe for memory data (REFILL)
//   mem_req/mem_we/mem_addr/mem_ready : memory handshake
// Handshake: mem_req is held with stable mem_we/mem_addr until mem_ready is seen
// with mem_req high; mem_req drops the following cycle, and mem_ready is
// ignored while mem_req is low. All outputs are registered.
module l2_cache_controller
  import l2_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               l1_req,
  input  logic               l1_we,
  input  logic [ADDR_W-1:0]  l1_addr,
  output logic               l2_ready,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [1:0]         way,
  output logic               update,
  output logic               refill,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready
);

  state_t           state, state_d;
  logic [TAG_W-1:0] tag_q;
  logic             we_q;
  logic [1:0]       way_d;

  logic [TAG_W-1:0] tags  [SETS][WAYS];
  logic [WAYS-1:0]  valid [SETS];
  logic [WAYS-1:0]  dirty [SETS];

  logic       hit;
  logic [1:0] hit_way;
  logic       has_invalid;
  logic [1:0] inv_way;
  logic [1:0] repl_way;
  logic [1:0] victim_way;
  logic       victim_dirty;
  logic       mem_hs;
  logic       unused_offset;

  assign mem_hs        = mem_req && mem_ready;
  assign unused_offset = ^l1_addr[OFFSET_W-1:0];

  l2_replace u_replace (
    .clk      (clk),
    .nrst     (nrst),
    .set_idx  (index_L1_L2),
    .touch    (state == DONE),
    .alloc    (state == REFILL),
    .used_way (way),
    .victim   (repl_way)
  );

  // Tag lookup on the latched request; the descending loop leaves the
  // lowest-numbered invalid way in inv_way.
  always_comb begin
    hit         = 1'b0;
    hit_way     = 2'd0;
    has_invalid = 1'b0;
    inv_way     = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[index_L1_L2][w] && (tags[index_L1_L2][w] == tag_q)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
      if (!valid[index_L1_L2][w]) begin
        has_invalid = 1'b1;
        inv_way     = 2'(w);
      end
    end
    victim_way   = has_invalid ? inv_way : repl_way;
    victim_dirty = valid[index_L1_L2][victim_way] && dirty[index_L1_L2][victim_way];
  end

  always_comb begin
    state_d = state;
    way_d   = way;
    case (state)
      IDLE:      if (l1_req) state_d = COMPARE;
      COMPARE: begin
        if (hit) begin
          way_d   = hit_way;
          state_d = DONE;
        end else begin
          way_d   = victim_way;
          state_d = victim_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: if (mem_hs) state_d = FETCH;
      FETCH:     if (mem_hs) state_d = REFILL;
      REFILL:    state_d = COMPARE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      tag_q       <= '0;
      we_q        <= 1'b0;
      index_L1_L2 <= '0;
      way         <= '0;
      l2_ready    <= 1'b0;
      update      <= 1'b0;
      refill      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      state <= state_d;
      way   <= way_d;
      if (state == IDLE && l1_req) begin
        tag_q       <= l1_addr[ADDR_W-1:ADDR_W-TAG_W];
        index_L1_L2 <= l1_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
        we_q        <= l1_we;
      end
      l2_ready <= (state_d == DONE);
      update   <= (state_d == DONE) && we_q;
      refill   <= (state_d == REFILL);
      // the !mem_hs term forces the one-cycle gap between WRITEBACK and FETCH
      mem_req  <= ((state_d == WRITEBACK) || (state_d == FETCH)) && !mem_hs;
      mem_we   <= (state_d == WRITEBACK);
      if (state_d == WRITEBACK)
        mem_addr <= line_addr(tags[index_L1_L2][way_d], index_L1_L2);
      else if (state_d == FETCH)
        mem_addr <= line_addr(tag_q, index_L1_L2);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      if (state == REFILL) begin
        valid[index_L1_L2][way] <= 1'b1;
        dirty[index_L1_L2][way] <= 1'b0;
      end else if (state == WRITEBACK && mem_hs) begin
        dirty[index_L1_L2][way] <= 1'b0;
      end else if (state == DONE && we_q) begin
        dirty[index_L1_L2][way] <= 1'b1;
      end
    end
  end

  // Tags need no reset: a tag is only looked at when its valid bit is set.
  always_ff @(posedge clk) begin
    if (nrst && state == REFILL) tags[index_L1_L2][way] <= tag_q;
  end

endmodule

// File: tb/tb_l2_cache_controller.sv
// Testbench for l2_cache_controller: reset check, a table of directed
// accesses, a reset-during-fetch sequence, and randomized accesses checked
// against a behavioural cache model. Honors L2_PLRU_EN in its model.
module tb_l2_cache_controller;

  logic        clk;
  logic        nrst;
  logic        l1_req;
  logic        l1_we;
  logic [31:0] l1_addr;
  logic        l2_ready;
  logic [4:0]  index_L1_L2;
  logic [1:0]  way;
  logic        update;
  logic        refill;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_ready;

  int tests;
  int fails;

  l2_cache_controller dut (
    .clk         (clk),
    .nrst        (nrst),
    .l1_req      (l1_req),
    .l1_we       (l1_we),
    .l1_addr     (l1_addr),
    .l2_ready    (l2_ready),
    .index_L1_L2 (index_L1_L2),
    .way         (way),
    .update      (update),
    .refill      (refill),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- records ----------------
  typedef struct {
    logic [31:0] addr;
    bit          we;
    int          delay;
    bit          exp_hit;
    bit          exp_wb;
    logic [31:0] exp_wb_addr;
    int          exp_way;
  } vec_t;

  typedef struct {
    bit          done;
    bit          wb_seen;
    bit          fetch_seen;
    bit          gap_low;
    bit          both;
    bit          upd;
    logic [31:0] wb_addr;
    logic [31:0] fetch_addr;
    int          refill_cnt;
    int          lat;
    logic [1:0]  refill_way;
    logic [1:0]  done_way;
    logic [4:0]  refill_idx;
    logic [4:0]  done_idx;
  } obs_t;

  // ---------------- reference model ----------------
  logic [20:0] m_tag  [32][4];
  bit          m_val  [32][4];
  bit          m_dty  [32][4];
  int          m_rr   [32];
  logic [2:0]  m_tree [32];

  function automatic void model_reset();
    for (int s = 0; s < 32; s++) begin
      for (int w = 0; w < 4; w++) begin
        m_val[s][w] = 1'b0;
        m_dty[s][w] = 1'b0;
        m_tag[s][w] = '0;
      end
      m_rr[s]   = 0;
      m_tree[s] = 3'b000;
    end
  endfunction

  function automatic void model_access(input logic [31:0] addr, input bit we,
                                       output bit hit, output bit wb,
                                       output logic [31:0] wb_addr, output int w_sel);
    int          s;
    logic [20:0] t;
    s       = int'(addr[10:6]);
    t       = addr[31:11];
    hit     = 1'b0;
    wb      = 1'b0;
    wb_addr = '0;
    w_sel   = -1;
    for (int w = 0; w < 4; w++)
      if (m_val[s][w] && m_tag[s][w] == t) begin
        hit   = 1'b1;
        w_sel = w;
      end
    if (!hit) begin
      for (int w = 3; w >= 0; w--)
        if (!m_val[s][w]) w_sel = w;
      if (w_sel < 0) begin
`ifdef L2_PLRU_EN
        w_sel = m_tree[s][0] ? 2 + int'(m_tree[s][2]) : int'(m_tree[s][1]);
`else
        w_sel = m_rr[s];
`endif
      end
      if (m_val[s][w_sel] && m_dty[s][w_sel]) begin
        wb      = 1'b1;
        wb_addr = {m_tag[s][w_sel], addr[10:6], 6'b0};
      end
      m_tag[s][w_sel] = t;
      m_val[s][w_sel] = 1'b1;
      m_dty[s][w_sel] = 1'b0;
      m_rr[s]         = (m_rr[s] + 1) % 4;
    end
    if (we) m_dty[s][w_sel] = 1'b1;
    // tree PLRU: mark the path to the touched way as recently used
    if (w_sel < 2) m_tree[s] = {m_tree[s][2], w_sel == 0, 1'b1};
    else           m_tree[s] = {w_sel == 2, m_tree[s][1], 1'b0};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver + memory responder ----------------
  task automatic run_access(input logic [31:0] addr, input bit we, input int d, output obs_t o);
    int cnt;
    bit hs_wb;
    o       = '{default: 0};
    cnt     = 0;
    hs_wb   = 1'b0;
    l1_addr = addr;
    l1_we   = we;
    l1_req  = 1'b1;
    for (int c = 1; c <= 300 && !o.done; c++) begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt       = 0;
        if (hs_wb) o.gap_low = !mem_req;
      end else if (mem_req) begin
        if (mem_we && !o.wb_seen) begin
          o.wb_seen = 1'b1;
          o.wb_addr = mem_addr;
        end
        if (!mem_we && !o.fetch_seen) begin
          o.fetch_seen = 1'b1;
          o.fetch_addr = mem_addr;
        end
        cnt++;
        if (cnt >= d) begin
          mem_ready = 1'b1;
          hs_wb     = mem_we;
        end
      end
      if (refill) begin
        o.refill_cnt++;
        o.refill_way = way;
        o.refill_idx = index_L1_L2;
      end
      if (refill && update) o.both = 1'b1;
      if (l2_ready) begin
        o.done     = 1'b1;
        o.lat      = c;
        o.done_way = way;
        o.done_idx = index_L1_L2;
        o.upd      = update;
        l1_req     = 1'b0;
      end
    end
    l1_req    = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic [31:0] addr, input bit we, input int d,
                           input bit eh, input bit ewb, input logic [31:0] ewa, input int ew);
    obs_t o;
    int   exp_lat;
    run_access(addr, we, d, o);
    exp_lat = eh ? 2 : (ewb ? 5 + 2 * d : 4 + d);
    chk("done_seen", 32'(o.done), 32'd1);
    chk("latency", 32'(o.lat), 32'(exp_lat));
    chk("miss_fetch", 32'(o.fetch_seen), 32'(!eh));
    chk("writeback", 32'(o.wb_seen), 32'(ewb));
    chk("done_way", 32'(o.done_way), 32'(ew));
    chk("done_index", 32'(o.done_idx), 32'(addr[10:6]));
    chk("update", 32'(o.upd), 32'(we));
    chk("strobe_excl", 32'(o.both), 32'd0);
    chk("refill_cnt", 32'(o.refill_cnt), eh ? 32'd0 : 32'd1);
    if (!eh) begin
      chk("fetch_addr", o.fetch_addr, {addr[31:6], 6'b0});
      chk("refill_way", 32'(o.refill_way), 32'(ew));
      chk("refill_index", 32'(o.refill_idx), 32'(addr[10:6]));
    end
    if (ewb) begin
      chk("wb_addr", o.wb_addr, ewa);
      chk("wb_gap", 32'(o.gap_low), 32'd1);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input bit we, input int d,
                              input bit h, input bit wb, input logic [31:0] wa, input int w);
    vec_t v;
    v.addr = a; v.we = we; v.delay = d; v.exp_hit = h;
    v.exp_wb = wb; v.exp_wb_addr = wa; v.exp_way = w;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl [12];

  initial begin
    bit          mh, mwb, seen;
    logic [31:0] mwa, addr;
    logic [20:0] t;
    int          mw;

    tests = 0;
    fails = 0;

    tbl[0]  = mk(32'h0000_0040, 1'b0, 3, 1'b0, 1'b0, 32'h0, 0);
    tbl[1]  = mk(32'h0000_0040, 1'b0, 1, 1'b1, 1'b0, 32'h0, 0);
    tbl[2]  = mk(32'h0000_0040, 1'b1, 1, 1'b1, 1'b0, 32'h0, 0);
    tbl[3]  = mk(32'h0000_0840, 1'b0, 2, 1'b0, 1'b0, 32'h0, 1);
    tbl[4]  = mk(32'h0000_1040, 1'b0, 1, 1'b0, 1'b0, 32'h0, 2);
    tbl[5]  = mk(32'h0000_1840, 1'b0, 2, 1'b0, 1'b0, 32'h0, 3);
    tbl[6]  = mk(32'h0000_2040, 1'b0, 2, 1'b0, 1'b1, 32'h0000_0040, 0);
    tbl[7]  = mk(32'h0000_0080, 1'b0, 1, 1'b0, 1'b0, 32'h0, 0);
    tbl[8]  = mk(32'h0000_0880, 1'b0, 1, 1'b0, 1'b0, 32'h0, 1);
    tbl[9]  = mk(32'h0000_1080, 1'b0, 1, 1'b0, 1'b0, 32'h0, 2);
    tbl[10] = mk(32'h0000_1880, 1'b0, 1, 1'b0, 1'b0, 32'h0, 3);
    tbl[11] = mk(32'h0000_2080, 1'b0, 1, 1'b0, 1'b0, 32'h0, 0);

    // reset
    nrst      = 1'b0;
    l1_req    = 1'b0;
    l1_we     = 1'b0;
    l1_addr   = '0;
    mem_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_l2_ready", 32'(l2_ready), 32'd0);
    chk("rst_index", 32'(index_L1_L2), 32'd0);
    chk("rst_way", 32'(way), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_refill", 32'(refill), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      model_access(tbl[i].addr, tbl[i].we, mh, mwb, mwa, mw);
      do_access(tbl[i].addr, tbl[i].we, tbl[i].delay,
                tbl[i].exp_hit, tbl[i].exp_wb, tbl[i].exp_wb_addr, tbl[i].exp_way);
    end

    // reset while waiting in FETCH
    l1_addr = 32'h0000_3040;
    l1_we   = 1'b0;
    l1_req  = 1'b1;
    seen    = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mem_req && !mem_we) seen = 1'b1;
    end
    chk("reach_fetch", 32'(seen), 32'd1);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_l2_ready", 32'(l2_ready), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    l1_req = 1'b0;
    nrst   = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    // previously cached line must miss into way 0 after invalidation
    model_access(32'h0000_2040, 1'b0, mh, mwb, mwa, mw);
    do_access(32'h0000_2040, 1'b0, 2, 1'b0, 1'b0, 32'h0, 0);

    // randomized accesses against the model
    for (int i = 0; i < 200; i++) begin
      t = 21'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) t = t | 21'h10_0000;
      addr = {t, 5'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      seen = ($urandom_range(0, 9) < 3);
      mw   = $urandom_range(1, 3);
      begin
        int d;
        d = mw;
        model_access(addr, seen, mh, mwb, mwa, mw);
        do_access(addr, seen, d, mh, mwb, mwa, mw);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
